upsp: RTL and testbench

Nearest-neighbour upsampling engine: the inverse-direction companion of the max-pooling layer. It reads an M-map pooled feature set of nIR×nIC pixels from one activation memory and writes an expanded set of (nIR·MP)×(nIC·MP) pixels into the next layer's input memory, replicating each source pixel over an MP×MP window. It sits between layer stages on the same read-port / write-port memory interfaces the other layer engines use, and raises `done` when the whole volume has been written.

---
 rtl/upsp.sv | 192 +++++++++++++++++++
 tb/tb_upsp.sv | 313 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/upsp.sv
// upsp: nearest-neighbour upsampling engine, replicates each pooled pixel over an MP x MP window.
// Build option UPSP_ZERO_FILL_EN: only each window's top-left position carries the pixel, others are 0.
module upsp #(
  parameter int DATA_SIZE = 16,
  parameter int MEM_SIZE  = 16,
  parameter int LOOP_BIT  = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 en,
  input  logic [DATA_SIZE-1:0] R,
  input  logic [DATA_SIZE-1:0] C,
  input  logic [DATA_SIZE-1:0] M,
  input  logic [DATA_SIZE-1:0] nIR,
  input  logic [DATA_SIZE-1:0] nIC,
  input  logic [DATA_SIZE-1:0] MP,
  input  logic [DATA_SIZE-1:0] src_rd,
  output logic                 done,
  output logic [MEM_SIZE-1:0]  src_ra,
  output logic                 dst_we,
  output logic [MEM_SIZE-1:0]  dst_wa,
  output logic [DATA_SIZE-1:0] dst_wd
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_e;

`ifdef UPSP_ZERO_FILL_EN
  localparam bit ZERO_FILL = 1'b1;
`else
  localparam bit ZERO_FILL = 1'b0;
`endif

  localparam logic [LOOP_BIT-1:0] L_ONE = LOOP_BIT'(1);

  state_e               state_q, state_d;
  logic [LOOP_BIT-1:0]  m_q, m_d, r_q, r_d, c_q, c_d, i_q, i_d, j_q, j_d;
  logic [1:0]           drain_q, drain_d;
  logic                 p1_valid_q, p1_valid_d, p1_first_q, p1_first_d;
  logic                 p2_valid_q, p2_valid_d, p2_first_q, p2_first_d;
  logic [MEM_SIZE-1:0]  p1_wa_q, p1_wa_d, p2_wa_q, p2_wa_d;
  logic [DATA_SIZE-1:0] hold_q, hold_d;
  logic                 done_q, done_d, dst_we_q, dst_we_d;
  logic [MEM_SIZE-1:0]  src_ra_q, src_ra_d, dst_wa_q, dst_wa_d;
  logic [DATA_SIZE-1:0] dst_wd_q, dst_wd_d;

  logic [LOOP_BIT-1:0]  m_n, r_n, c_n, p_n;
  logic                 j_last, i_last, c_last, r_last, m_last, zero_dim;
  logic [MEM_SIZE-1:0]  map_row, dst_row, dst_width, src_addr, dst_addr;

  // Loop bounds and addresses of the current loop point; all arithmetic wraps at MEM_SIZE bits.
  always_comb begin
    m_n       = M[LOOP_BIT-1:0];
    r_n       = nIR[LOOP_BIT-1:0];
    c_n       = nIC[LOOP_BIT-1:0];
    p_n       = MP[LOOP_BIT-1:0];
    j_last    = (j_q == p_n - L_ONE);
    i_last    = (i_q == p_n - L_ONE);
    c_last    = (c_q == c_n - L_ONE);
    r_last    = (r_q == r_n - L_ONE);
    m_last    = (m_q == m_n - L_ONE);
    zero_dim  = (M == '0) || (nIR == '0) || (nIC == '0) || (MP == '0);
    map_row   = MEM_SIZE'(m_q) * MEM_SIZE'(nIR) + MEM_SIZE'(r_q);
    dst_row   = map_row * MEM_SIZE'(MP) + MEM_SIZE'(i_q);
    dst_width = MEM_SIZE'(nIC) * MEM_SIZE'(MP);
    src_addr  = MEM_SIZE'(R) + map_row * MEM_SIZE'(nIC) + MEM_SIZE'(c_q);
    dst_addr  = MEM_SIZE'(C) + dst_row * dst_width + MEM_SIZE'(c_q) * MEM_SIZE'(MP)
              + MEM_SIZE'(j_q);
  end

  always_comb begin
    state_d    = state_q;
    m_d        = m_q;
    r_d        = r_q;
    c_d        = c_q;
    i_d        = i_q;
    j_d        = j_q;
    drain_d    = drain_q;
    done_d     = 1'b0;
    src_ra_d   = src_ra_q;
    p1_valid_d = 1'b0;
    p1_first_d = (i_q == '0) && (j_q == '0);
    p1_wa_d    = dst_addr;
    case (state_q)
      IDLE: begin
        if (en) begin
          m_d = '0;
          r_d = '0;
          c_d = '0;
          i_d = '0;
          j_d = '0;
          if (zero_dim) begin
            state_d = DONE;
            done_d  = 1'b1;
          end else begin
            state_d = RUN;
          end
        end
      end
      RUN: begin
        p1_valid_d = 1'b1;
        src_ra_d   = src_addr;
        j_d = j_last ? '0 : j_q + L_ONE;
        if (j_last) i_d = i_last ? '0 : i_q + L_ONE;
        if (j_last && i_last) c_d = c_last ? '0 : c_q + L_ONE;
        if (j_last && i_last && c_last) r_d = r_last ? '0 : r_q + L_ONE;
        if (j_last && i_last && c_last && r_last) m_d = m_last ? '0 : m_q + L_ONE;
        if (j_last && i_last && c_last && r_last && m_last) begin
          state_d = DRAIN;
          drain_d = 2'd0;
        end
      end
      DRAIN: begin
        drain_d = drain_q + 2'd1;
        if (drain_q == 2'd2) begin
          state_d = DONE;
          done_d  = 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Stage 2 waits for the read data; stage 3 registers the write.
    p2_valid_d = p1_valid_q;
    p2_first_d = p1_first_q;
    p2_wa_d    = p1_wa_q;
    dst_we_d   = p2_valid_q;
    dst_wa_d   = dst_wa_q;
    dst_wd_d   = dst_wd_q;
    hold_d     = hold_q;
    if (p2_valid_q) begin
      dst_wa_d = p2_wa_q;
      if (p2_first_q) begin
        hold_d   = src_rd;
        dst_wd_d = src_rd;
      end else begin
        dst_wd_d = ZERO_FILL ? '0 : hold_q;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      m_q        <= '0;
      r_q        <= '0;
      c_q        <= '0;
      i_q        <= '0;
      j_q        <= '0;
      drain_q    <= '0;
      p1_valid_q <= 1'b0;
      p1_first_q <= 1'b0;
      p1_wa_q    <= '0;
      p2_valid_q <= 1'b0;
      p2_first_q <= 1'b0;
      p2_wa_q    <= '0;
      hold_q     <= '0;
      done_q     <= 1'b0;
      src_ra_q   <= '0;
      dst_we_q   <= 1'b0;
      dst_wa_q   <= '0;
      dst_wd_q   <= '0;
    end else begin
      state_q    <= state_d;
      m_q        <= m_d;
      r_q        <= r_d;
      c_q        <= c_d;
      i_q        <= i_d;
      j_q        <= j_d;
      drain_q    <= drain_d;
      p1_valid_q <= p1_valid_d;
      p1_first_q <= p1_first_d;
      p1_wa_q    <= p1_wa_d;
      p2_valid_q <= p2_valid_d;
      p2_first_q <= p2_first_d;
      p2_wa_q    <= p2_wa_d;
      hold_q     <= hold_d;
      done_q     <= done_d;
      src_ra_q   <= src_ra_d;
      dst_we_q   <= dst_we_d;
      dst_wa_q   <= dst_wa_d;
      dst_wd_q   <= dst_wd_d;
    end
  end

  assign done   = done_q;
  assign src_ra = src_ra_q;
  assign dst_we = dst_we_q;
  assign dst_wa = dst_wa_q;
  assign dst_wd = dst_wd_q;

endmodule

// File: tb/tb_upsp.sv
// tb_upsp: self-checking bench for upsp against a pixel-coordinate model of the upsampled image.
// Handshake: en is a one-cycle start pulse taken only in IDLE; done pulses once when the volume is written.
module tb_upsp;
  localparam int DW = 16;
  localparam int AW = 16;
`ifdef UPSP_ZERO_FILL_EN
  localparam bit ZF = 1'b1;
`else
  localparam bit ZF = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          en  = 1'b0;
  logic [DW-1:0] r_base = '0, c_base = '0, m_n = '0, nir_n = '0, nic_n = '0, mp_n = '0;
  logic [DW-1:0] src_rd = '0;
  logic          done, dst_we;
  logic [AW-1:0] src_ra, dst_wa;
  logic [DW-1:0] dst_wd;

  logic [DW-1:0] mem [65536];
  logic [31:0]   exp_q[$];
  logic [31:0]   got_q[$];
  int            got_cyc_q[$];
  int            done_cyc_q[$];
  int            checks = 0, errors = 0, cyc = 0, start_cyc = 0;

  upsp #(.DATA_SIZE(DW), .MEM_SIZE(AW), .LOOP_BIT(8)) dut (
    .clk(clk), .rst(rst), .en(en), .R(r_base), .C(c_base), .M(m_n), .nIR(nir_n),
    .nIC(nic_n), .MP(mp_n), .src_rd(src_rd), .done(done), .src_ra(src_ra),
    .dst_we(dst_we), .dst_wa(dst_wa), .dst_wd(dst_wd)
  );

  // Clock/reset block; the source memory answers one cycle after the address.
  always #5 clk = ~clk;
  always @(posedge clk) begin
    cyc    <= cyc + 1;
    src_rd <= mem[src_ra];
  end

  always @(negedge clk) begin
    if (dst_we === 1'b1) begin
      got_q.push_back({dst_wa, dst_wd});
      got_cyc_q.push_back(cyc);
    end
    if (done === 1'b1) done_cyc_q.push_back(cyc);
  end

  // Output image pixel (y, x) of map m copies source pixel (y/p, x/p); writes follow the m,r,c,i,j order.
  function automatic void build_expected(input int rb, cb, mm, ir, ic, p);
    int oh, ow, y, x;
    logic [AW-1:0] sa, da;
    logic [DW-1:0] v;
    oh = ir * p;
    ow = ic * p;
    for (int m = 0; m < mm; m++)
      for (int r = 0; r < ir; r++)
        for (int c = 0; c < ic; c++)
          for (int i = 0; i < p; i++)
            for (int j = 0; j < p; j++) begin
              y  = r * p + i;
              x  = c * p + j;
              da = AW'(cb + (m * oh + y) * ow + x);
              sa = AW'(rb + (m * ir + y / p) * ic + x / p);
              v  = (ZF && ((y % p) != 0 || (x % p) != 0)) ? '0 : mem[sa];
              exp_q.push_back({da, v});
            end
  endfunction

  task automatic clear_sb();
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    done_cyc_q.delete();
  endtask

  task automatic start_op(input int rb, cb, mm, ir, ic, p);
    @(posedge clk);
    #1;
    r_base = DW'(rb); c_base = DW'(cb); m_n = DW'(mm);
    nir_n = DW'(ir); nic_n = DW'(ic); mp_n = DW'(p);
    en = 1'b1;
    start_cyc = cyc + 1;
    @(posedge clk);
    #1;
    en = 1'b0;
  endtask

  task automatic wait_done(input int budget, input int tail, output bit timed_out);
    timed_out = 1'b1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        timed_out = 1'b0;
        break;
      end
    end
    repeat (tail) @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got %b exp 0", done); end
    checks++; if (dst_we !== 1'b0) begin errors++; $display("FAIL reset_we got %b exp 0", dst_we); end
    checks++; if (src_ra !== '0) begin errors++; $display("FAIL reset_ra got %h exp 0", src_ra); end
    checks++; if (dst_wa !== '0) begin errors++; $display("FAIL reset_wa got %h exp 0", dst_wa); end
    checks++; if (dst_wd !== '0) begin errors++; $display("FAIL reset_wd got %h exp 0", dst_wd); end
    rst = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_basic();
    bit to;
    int lit [16];
    logic [DW-1:0] img [int];
    if (ZF) lit = '{1, 0, 2, 0, 0, 0, 0, 0, 3, 0, 4, 0, 0, 0, 0, 0};
    else    lit = '{1, 1, 2, 2, 1, 1, 2, 2, 3, 3, 4, 4, 3, 3, 4, 4};
    clear_sb();
    for (int k = 0; k < 4; k++) mem[k] = DW'(k + 1);
    build_expected(0, 100, 1, 2, 2, 2);
    start_op(0, 100, 1, 2, 2, 2);
    wait_done(200, 4, to);
    checks++; if (to) begin errors++; $display("FAIL basic_timeout got no done exp done"); end
    checks++; if (got_q.size() != 16) begin errors++; $display("FAIL basic_count got %0d exp 16", got_q.size()); end
    foreach (got_q[k]) begin
      img[int'(got_q[k][31:16])] = got_q[k][15:0];
      if (k < exp_q.size()) begin
        checks++;
        if (got_q[k] !== exp_q[k] || got_cyc_q[k] != start_cyc + 3 + k) begin
          errors++;
          $display("FAIL basic_write%0d got %h@%0d exp %h@%0d", k, got_q[k], got_cyc_q[k], exp_q[k], start_cyc + 3 + k);
        end
      end
    end
    for (int a = 0; a < 16; a++) begin
      checks++;
      if (!img.exists(100 + a) || img[100 + a] !== DW'(lit[a])) begin
        errors++;
        $display("FAIL basic_image addr %0d got %h exp %0d", 100 + a, img.exists(100 + a) ? img[100 + a] : 'x, lit[a]);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + 19) begin
      errors++;
      $display("FAIL basic_done got %0d pulses first@%0d exp 1@%0d", done_cyc_q.size(),
               done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, start_cyc + 19);
    end
  endtask

  task automatic test_copy();
    bit to;
    clear_sb();
    for (int k = 10; k < 16; k++) mem[k] = DW'($urandom);
    build_expected(10, 50, 2, 1, 3, 1);
    start_op(10, 50, 2, 1, 3, 1);
    wait_done(200, 4, to);
    checks++; if (to) begin errors++; $display("FAIL copy_timeout got no done exp done"); end
    checks++; if (got_q.size() != 6) begin errors++; $display("FAIL copy_count got %0d exp 6", got_q.size()); end
    foreach (got_q[k]) if (k < 6) begin
      checks++;
      if (got_q[k] !== {AW'(50 + k), mem[10 + k]} || got_cyc_q[k] != start_cyc + 3 + k) begin
        errors++;
        $display("FAIL copy_write%0d got %h@%0d exp %h@%0d", k, got_q[k], got_cyc_q[k], {AW'(50 + k), mem[10 + k]}, start_cyc + 3 + k);
      end
    end
    checks++;
    if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + 9) begin
      errors++;
      $display("FAIL copy_done got %0d pulses exp 1@%0d", done_cyc_q.size(), start_cyc + 9);
    end
  endtask

  task automatic test_zero_dim();
    bit to;
    int dims [4];
    for (int z = 0; z < 4; z++) begin
      clear_sb();
      dims = '{2, 2, 2, 2};
      dims[z] = 0;
      start_op(0, 300, dims[0], dims[1], dims[2], dims[3]);
      wait_done(20, 6, to);
      checks++; if (to) begin errors++; $display("FAIL zero%0d_timeout got no done exp done", z); end
      checks++; if (got_q.size() != 0) begin errors++; $display("FAIL zero%0d_writes got %0d exp 0", z, got_q.size()); end
      checks++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc) begin
        errors++;
        $display("FAIL zero%0d_done got %0d pulses first@%0d exp 1@%0d", z, done_cyc_q.size(),
                 done_cyc_q.size() > 0 ? done_cyc_q[0] : -1, start_cyc);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit to;
    int n_at_rst;
    clear_sb();
    for (int k = 0; k < 4; k++) mem[k] = DW'(k + 1);
    start_op(0, 100, 1, 2, 2, 2);
    for (int k = 0; k < 100 && got_q.size() < 5; k++) @(negedge clk);
    #1;
    rst = 1'b0;
    n_at_rst = got_q.size();
    @(negedge clk);
    checks++;
    if ({done, dst_we, src_ra, dst_wa, dst_wd} !== '0) begin
      errors++;
      $display("FAIL midrst_outputs got %b/%b/%h/%h/%h exp all 0", done, dst_we, src_ra, dst_wa, dst_wd);
    end
    repeat (3) @(negedge clk);
    rst = 1'b1;
    repeat (30) @(negedge clk);
    checks++; if (got_q.size() != n_at_rst) begin errors++; $display("FAIL midrst_writes got %0d exp %0d", got_q.size(), n_at_rst); end
    checks++; if (done_cyc_q.size() != 0) begin errors++; $display("FAIL midrst_done got %0d exp 0", done_cyc_q.size()); end
    clear_sb();
    build_expected(0, 100, 1, 2, 2, 2);
    start_op(0, 100, 1, 2, 2, 2);
    wait_done(200, 4, to);
    checks++; if (to || got_q.size() != 16) begin errors++; $display("FAIL midrst_rerun got %0d writes exp 16", got_q.size()); end
    foreach (got_q[k]) if (k < 16) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL midrst_write%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
  endtask

  task automatic test_en_ignored();
    bit to;
    clear_sb();
    build_expected(0, 100, 1, 2, 2, 2);
    start_op(0, 100, 1, 2, 2, 2);
    repeat (6) @(posedge clk);
    #1 en = 1'b1;
    @(posedge clk);
    #1 en = 1'b0;
    wait_done(200, 20, to);
    checks++; if (to || got_q.size() != 16) begin errors++; $display("FAIL enign_count got %0d exp 16", got_q.size()); end
    foreach (got_q[k]) if (k < 16) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL enign_write%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++; if (done_cyc_q.size() != 1) begin errors++; $display("FAIL enign_done got %0d exp 1", done_cyc_q.size()); end
  endtask

  task automatic test_back_to_back();
    bit to;
    int sa_cyc, ka;
    clear_sb();
    build_expected(7, 900, 1, 2, 3, 2);
    ka = exp_q.size();
    build_expected(40, 2000, 2, 2, 1, 3);
    start_op(7, 900, 1, 2, 3, 2);
    sa_cyc = start_cyc;
    wait_done(300, 0, to);
    start_op(40, 2000, 2, 2, 1, 3);
    wait_done(300, 4, to);
    checks++; if (got_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count got %0d exp %0d", got_q.size(), exp_q.size()); end
    foreach (got_q[k]) if (k < exp_q.size()) begin
      checks++;
      if (got_q[k] !== exp_q[k]) begin errors++; $display("FAIL b2b_write%0d got %h exp %h", k, got_q[k], exp_q[k]); end
    end
    checks++;
    if (done_cyc_q.size() != 2 || start_cyc != sa_cyc + ka + 5 || done_cyc_q[1] != start_cyc + (exp_q.size() - ka) + 3) begin
      errors++;
      $display("FAIL b2b_timing got %0d pulses second start@%0d exp 2 pulses start@%0d", done_cyc_q.size(), start_cyc, sa_cyc + ka + 5);
    end
  endtask

  task automatic test_random();
    bit to;
    int rb, cb, mm, ir, ic, p;
    for (int it = 0; it < 8; it++) begin
      clear_sb();
      rb = $urandom_range(0, 65535); cb = $urandom_range(0, 65535);
      mm = $urandom_range(1, 3); ir = $urandom_range(1, 4);
      ic = $urandom_range(1, 4); p  = $urandom_range(1, 3);
      build_expected(rb, cb, mm, ir, ic, p);
      start_op(rb, cb, mm, ir, ic, p);
      wait_done(1000, 4, to);
      checks++;
      if (to || got_q.size() != exp_q.size()) begin
        errors++;
        $display("FAIL rand%0d_count got %0d exp %0d", it, got_q.size(), exp_q.size());
      end
      foreach (got_q[k]) if (k < exp_q.size()) begin
        checks++;
        if (got_q[k] !== exp_q[k] || got_cyc_q[k] != start_cyc + 3 + k) begin
          errors++;
          $display("FAIL rand%0d_write%0d got %h@%0d exp %h@%0d", it, k, got_q[k], got_cyc_q[k], exp_q[k], start_cyc + 3 + k);
        end
      end
      checks++;
      if (done_cyc_q.size() != 1 || done_cyc_q[0] != start_cyc + exp_q.size() + 3) begin
        errors++;
        $display("FAIL rand%0d_done got %0d pulses exp 1@%0d", it, done_cyc_q.size(), start_cyc + exp_q.size() + 3);
      end
    end
  endtask

  initial begin
    for (int a = 0; a < 65536; a++) mem[a] = DW'($urandom);
    test_reset();
    test_basic();
    test_copy();
    test_zero_dim();
    test_reset_mid();
    test_en_ignored();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
